mem_stage_sb: RTL
=================

// Module: mem_stage_sb
// PURPOSE
//  Next-gen MEM pipeline stage: accepts EX-stage ops, issues loads/stores to the dcache, returns formatted load data to WB.
//  Stores retire into a DEPTH-entry in-order store buffer (SB), then drain to the dcache in the background, so stores no longer stall the pipe.
//  Loads are byte/half/word aligned and sign/zero-extended in-stage, replacing the external rdata register.
// PARAMETERS
//  XLEN   32  data/address width (multiple of 8)
//  DEPTH  4   store buffer entries (power of 2, >=2)
//  RDW    5   destination register index width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  in_valid     in   1       EX op valid
//  in_ready     out  1       stage accepts op this cycle
//  in_read      in   1       op is a load
//  in_write     in   1       op is a store (never together with in_read)
//  in_funct3    in   3       000 b, 001 h, 010 w, 100 bu, 101 hu
//  in_addr      in   XLEN    effective address (ALU result)
//  in_wdata     in   XLEN    store data, rs2, unshifted
//  in_alu       in   XLEN    ALU result forwarded for non-memory ops
//  in_rd        in   RDW     destination register
//  out_valid    out  1       WB result valid
//  out_ready    in   1       WB accepts result
//  out_data     out  XLEN    load data or in_alu
//  out_rd       out  RDW     destination register (0 for stores)
//  out_misalign out  1       op was misaligned; qualified by out_valid
//  dc_read      out  1       dcache read request
//  dc_write     out  1       dcache write request
//  dc_addr      out  XLEN    word-aligned dcache address
//  dc_wdata     out  XLEN    byte-lane-positioned write data
//  dc_wmask     out  XLEN/8  byte write enables
//  dc_resp      in   1       1-cycle completion pulse
//  dc_rdata     in   XLEN    read data, valid with dc_resp
//  sb_empty     out  1       store buffer empty (fence/debug)
// BEHAVIOUR
//  Reset (reset=0): outputs 0, except in_ready=1 and sb_empty=1; FSM IDLE; SB pointers 0. Applies immediately and aborts any in-flight request.
//  Handshakes: in_valid&in_ready accepts. out_valid holds with stable data until out_ready.
//  Output register: single. in_ready=0 while out_valid&~out_ready.
//  Non-mem op: registered to out_data=in_alu; latency 1.
//  Store enqueue: when SB not full -> byte-shifted data and mask (store_mask rules) enter SB; out_valid next cycle, out_rd=0. SB full -> in_ready=0.
//  FSM IDLE->LOAD_WAIT: accepted load is allowed to issue (SB empty, or forwarded) -> dc_read=1, in_ready=0.
//  FSM IDLE->STORE_WAIT: no load waiting and SB not empty -> dc_write=1 for SB head.
//  WAIT: request and addr/data/mask held stable until dc_resp.
//  dc_resp in LOAD_WAIT: extend the selected lane, register to out_data, go to IDLE; total latency = dcache latency + 1.
//  dc_resp in STORE_WAIT: pop SB head, go to IDLE. No back-to-back issue; IDLE always takes >=1 cycle.
//  Load ordering: a load waits in IDLE until the SB is empty (drain first), so RAW through memory is always correct.
//  Same-cycle enqueue and pop: count unchanged. Pointers wrap modulo DEPTH.
//  Misaligned accesses are not sent to the dcache: h with addr[0]=1, w with addr[1:0]!=0. They complete in 1 cycle with out_misalign=1 and out_data=0.
// CONFIGURATION
//  STORE_FWD_EN defined: a load whose word matches an SB entry uses the youngest matching entry.
//   If that entry's mask covers all requested bytes -> data forwarded, latency 1, no dcache access.
//   Partial cover -> waits for SB empty (same as the undefined case). A non-matching load issues without waiting for drain.
//  STORE_FWD_EN undefined: no compare logic; every load drains the SB first.
// TESTING
//  Reset mid-STORE_WAIT with dc_write=1 -> next cycle dc_write=0, sb_empty=1, in_ready=1.
//  5 stores back-to-back, DEPTH=4, dc_resp stuck 0 -> 5th held (in_ready=0) until first dc_resp; dcache sees stores in program order.
//  sb @0x100 data 0x000000F0; lb @0x100 -> out_data=0xFFFFFFF0. lbu @0x100 -> out_data=0x000000F0.
//  sh @0x102 data 0xBEEF -> dc_wmask=1100, dc_wdata=0xBEEF0000, dc_addr=0x100.
//  lw @0x101 -> out_misalign=1, no dc_read pulse, out_valid after 1 cycle.
//  STORE_FWD_EN: sw @0x200 0x12345678 then lw @0x200, dc_resp=0 -> out_data=0x12345678 in 1 cycle, dc_read never set. Undefined: load issues only after dc_write completes.
//  out_ready=0 for 3 cycles on a valid result -> out_data/out_rd stable, in_ready=0 throughout.

Source files
------------

// File: rtl/mem_stage_sb.sv
// MEM stage: load/store to dcache through an in-order store buffer.
// Optional macro STORE_FWD_EN: forward loads fully covered by a buffered store.
module mem_stage_sb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RDW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_read,
  input  logic              in_write,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [RDW-1:0]    in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [RDW-1:0]    out_rd,
  output logic              out_misalign,
  output logic              dc_read,
  output logic              dc_write,
  output logic [XLEN-1:0]   dc_addr,
  output logic [XLEN-1:0]   dc_wdata,
  output logic [XLEN/8-1:0] dc_wmask,
  input  logic              dc_resp,
  input  logic [XLEN-1:0]   dc_rdata,
  output logic              sb_empty
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = XLEN - OW;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    STORE_WAIT
  } state_t;

  function automatic logic [NB-1:0] lane_mask(
    input logic [1:0]    sz,
    input logic [OW-1:0] off
  );
    logic [NB-1:0] m;
    unique case (1'b1)
      sz == 2'b00: m = NB'(1);
      sz == 2'b01: m = NB'(3);
      default:     m = '1;
    endcase
    return m << off;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(
    input logic [XLEN-1:0] w,
    input logic [2:0]      f,
    input logic [OW-1:0]   off
  );
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] r;
    s = w >> {off, 3'b000};
    unique case (1'b1)
      f[1:0] == 2'b00: r = {{(XLEN-8){~f[2] & s[7]}}, s[7:0]};
      f[1:0] == 2'b01: r = {{(XLEN-16){~f[2] & s[15]}}, s[15:0]};
      default:         r = s;
    endcase
    return r;
  endfunction

  state_t          state;
  logic [PW:0]     cnt;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [WW-1:0]   sb_wa   [DEPTH];
  logic [XLEN-1:0] sb_data [DEPTH];
  logic [NB-1:0]   sb_mask [DEPTH];

  logic            ld_pend;
  logic            ld_free;
  logic [2:0]      ld_f3;
  logic [OW-1:0]   ld_off;
  logic [WW-1:0]   ld_wa;
  logic [RDW-1:0]  ld_rd;

  logic [OW-1:0]   off;
  logic [WW-1:0]   wa;
  logic [NB-1:0]   req_mask;
  logic            mis;
  logic            acc;
  logic            enq;
  logic            pop;
  logic            sb_full;
  logic            ld_busy;
  logic            fwd_hit;
  logic            fwd_free;
  logic [XLEN-1:0] fwd_out;

  assign off      = in_addr[OW-1:0];
  assign wa       = in_addr[XLEN-1:OW];
  assign req_mask = lane_mask(in_funct3[1:0], off);
  assign mis      = (in_read | in_write) &
                    ((in_funct3[1:0] == 2'b01 & off[0]) |
                     (in_funct3[1] & |off));
  assign sb_full  = cnt == (PW+1)'(DEPTH);
  assign sb_empty = cnt == '0;
  assign ld_busy  = ld_pend | (state == LOAD_WAIT);
  assign in_ready = (~out_valid | out_ready) & ~ld_busy & ~sb_full;
  assign acc      = in_valid & in_ready;
  assign enq      = acc & in_write & ~mis;
  assign pop      = (state == STORE_WAIT) & dc_resp;

`ifdef STORE_FWD_EN
  logic            fwd_match;
  logic [NB-1:0]   fwd_mask;
  logic [XLEN-1:0] fwd_data;
  logic [PW-1:0]   fwd_idx;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_match = 1'b0;
    fwd_mask  = '0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rptr + PW'(i);
      if ((PW+1)'(i) < cnt && sb_wa[fwd_idx] == wa) begin
        fwd_match = 1'b1;
        fwd_mask  = sb_mask[fwd_idx];
        fwd_data  = sb_data[fwd_idx];
      end
    end
  end

  assign fwd_hit  = in_read & fwd_match &
                    ((fwd_mask & req_mask) == req_mask);
  assign fwd_free = ~fwd_match;
  assign fwd_out  = load_ext(fwd_data, in_funct3, off);
`else
  assign fwd_hit  = 1'b0;
  assign fwd_free = 1'b0;
  assign fwd_out  = '0;
`endif

  always_ff @(posedge clk) begin
    if (enq) begin
      sb_wa[wptr]   <= wa;
      sb_data[wptr] <= in_wdata << {off, 3'b000};
      sb_mask[wptr] <= req_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (PW+1)'(enq) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      dc_read      <= 1'b0;
      dc_write     <= 1'b0;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      dc_wmask     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_rd       <= '0;
      out_misalign <= 1'b0;
      ld_pend      <= 1'b0;
      ld_free      <= 1'b0;
      ld_f3        <= '0;
      ld_off       <= '0;
      ld_wa        <= '0;
      ld_rd        <= '0;
    end else begin
      if (state == LOAD_WAIT && dc_resp) begin
        out_valid    <= 1'b1;
        out_data     <= load_ext(dc_rdata, ld_f3, ld_off);
        out_rd       <= ld_rd;
        out_misalign <= 1'b0;
      end else if (acc && (!in_read || mis || fwd_hit)) begin
        out_valid    <= 1'b1;
        out_data     <= (in_write || mis) ? '0 :
                        (fwd_hit ? fwd_out : in_alu);
        out_rd       <= in_write ? '0 : in_rd;
        out_misalign <= mis;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (acc && in_read && !mis && !fwd_hit) begin
        ld_pend <= 1'b1;
        ld_free <= fwd_free;
        ld_f3   <= in_funct3;
        ld_off  <= off;
        ld_wa   <= wa;
        ld_rd   <= in_rd;
      end

      unique case (state)
        LOAD_WAIT: begin
          if (dc_resp) begin
            state   <= IDLE;
            dc_read <= 1'b0;
          end
        end
        STORE_WAIT: begin
          if (dc_resp) begin
            state    <= IDLE;
            dc_write <= 1'b0;
          end
        end
        default: begin
          if (ld_pend && (sb_empty || ld_free)) begin
            state    <= LOAD_WAIT;
            dc_read  <= 1'b1;
            dc_addr  <= {ld_wa, {OW{1'b0}}};
            dc_wmask <= '0;
            ld_pend  <= 1'b0;
          end else if (!sb_empty) begin
            state    <= STORE_WAIT;
            dc_write <= 1'b1;
            dc_addr  <= {sb_wa[rptr], {OW{1'b0}}};
            dc_wdata <= sb_data[rptr];
            dc_wmask <= sb_mask[rptr];
          end
        end
      endcase
    end
  end

endmodule
